// File: rtl/vec_cmp_pkg.sv
// Shared encodings for the vector compare controller: compare ops, SEW codes,
// FSM states and the default mask-pack width.
package vec_cmp_pkg;

  localparam int PACK_W_DEF = 32;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LTU = 3'b010,
    CMP_LEU = 3'b011,
    CMP_LT  = 3'b100,
    CMP_LE  = 3'b101,
    CMP_GT  = 3'b110,
    CMP_GTU = 3'b111
  } cmp_op_e;

  localparam logic [1:0] SEW_8   = 2'b00;
  localparam logic [1:0] SEW_16  = 2'b01;
  localparam logic [1:0] SEW_32  = 2'b10;
  localparam logic [1:0] SEW_BAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    PACK   = 2'b10,
    DONE   = 2'b11
  } state_e;

  // Element count that fits in one vector register at the given SEW.
  function automatic int unsigned vlmax(int unsigned vlen, logic [1:0] sew);
    return vlen >> (32'd3 + 32'(sew));
  endfunction

endpackage

// File: rtl/vec_mask_pack_slice.sv
// Combinational: builds one PACK_W-bit chunk of the destination mask starting at element idx.
// Active, enabled elements take the compare bit at element LSB; others keep old_vd.
module vec_mask_pack_slice
  import vec_cmp_pkg::*;
#(
  parameter int VLEN   = 4096,
  parameter int PACK_W = PACK_W_DEF,
  parameter int IW     = $clog2(VLEN) + 1
) (
  input  logic [VLEN-1:0]   cmp_result,
  input  logic [VLEN-1:0]   v0,
  input  logic [VLEN-1:0]   old_vd,
  input  logic [IW-1:0]     idx,
  input  logic [IW-1:0]     vl,
  input  logic              vm,
  input  logic [1:0]        sew,
  output logic [PACK_W-1:0] chunk
);

  localparam int AW = $clog2(VLEN);

  for (genvar j = 0; j < PACK_W; j++) begin : g_bit
    logic [31:0]   e;
    logic [AW-1:0] pos;
    logic          active;

    assign e      = 32'(idx) + 32'(j);
    assign active = (e < 32'(vl)) && (vm || v0[e[AW-1:0]]);
    // pos only matters for e < vl, where it is guaranteed to be below VLEN.
    assign pos    = (sew == SEW_8)  ? AW'(e << 3) :
                    (sew == SEW_16) ? AW'(e << 4) : AW'(e << 5);
    assign chunk[j] = active ? cmp_result[pos] : old_vd[e[AW-1:0]];
  end

endmodule

// File: rtl/vec_compare_ctrl.sv
// Vector compare controller: latches a request, drives the compare datapath, packs the mask.
// Mask ready 2+ceil(vl/PACK_W) cycles after accept; held in DONE until mask_ready.
module vec_compare_ctrl
  import vec_cmp_pkg::*;
#(
  parameter int VLEN   = 4096,
  parameter int PACK_W = PACK_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_cmp_op,
  input  logic [1:0]      req_sew,
  input  logic [12:0]     req_vl,
  input  logic            req_vm,
  input  logic [VLEN-1:0] req_vs1,
  input  logic [VLEN-1:0] req_vs2,
  input  logic [VLEN-1:0] req_v0,
  input  logic [VLEN-1:0] req_old_vd,
  output logic [VLEN-1:0] cmp_a,
  output logic [VLEN-1:0] cmp_b,
  output logic [2:0]      cmp_op,
  output logic [1:0]      cmp_sew,
  input  logic [VLEN-1:0] cmp_result,
  output logic [VLEN-1:0] mask_out,
  output logic            mask_valid,
  input  logic            mask_ready,
  output logic            busy,
  output logic            err_sew
);

  localparam int AW = $clog2(VLEN);
  localparam int IW = AW + 1;

  state_e            state, nxt;
  logic [IW-1:0]     idx, vl_q, acc_vl;
  logic              vm_q, err_q, pack_last;
  logic [VLEN-1:0]   v0_q, mask_q;
  logic [PACK_W-1:0] chunk;
  int unsigned       lim;

  always_comb begin
    lim    = vlmax(VLEN, req_sew);
    acc_vl = (32'(req_vl) > lim) ? IW'(lim) : IW'(req_vl);
  end

  assign pack_last = (32'(idx) + 32'(PACK_W)) >= 32'(vl_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    mask_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = LAUNCH;
      end
      LAUNCH: nxt = ((vl_q == '0) || (cmp_sew == SEW_BAD)) ? DONE : PACK;
      PACK:   if (pack_last) nxt = DONE;
      DONE: begin
        mask_valid = 1'b1;
        if (mask_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // The mask register is preloaded with old_vd, so unprocessed bits already
  // hold the undisturbed value and double as the slice's old_vd source.
  vec_mask_pack_slice #(.VLEN(VLEN), .PACK_W(PACK_W), .IW(IW)) u_slice (
    .cmp_result (cmp_result),
    .v0         (v0_q),
    .old_vd     (mask_q),
    .idx        (idx),
    .vl         (vl_q),
    .vm         (vm_q),
    .sew        (cmp_sew),
    .chunk      (chunk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      vl_q    <= '0;
      vm_q    <= 1'b0;
      err_q   <= 1'b0;
      v0_q    <= '0;
      mask_q  <= '0;
      cmp_a   <= '0;
      cmp_b   <= '0;
      cmp_op  <= '0;
      cmp_sew <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cmp_a   <= req_vs2;
          cmp_b   <= req_vs1;
          cmp_op  <= req_cmp_op;
          cmp_sew <= req_sew;
          vl_q    <= acc_vl;
          vm_q    <= req_vm;
          v0_q    <= req_v0;
          mask_q  <= req_old_vd;
          err_q   <= (req_sew == SEW_BAD);
          idx     <= '0;
        end
        PACK: begin
          mask_q[idx[AW-1:0] +: PACK_W] <= chunk;
          idx <= idx + IW'(PACK_W);
        end
        default: ;
      endcase
    end
  end

  assign mask_out = mask_q;
  assign busy     = (state != IDLE);
  assign err_sew  = err_q && (state == DONE);

endmodule

// File: tb/tb_vec_compare_ctrl.sv
// Scoreboard bench for vec_compare_ctrl: directed requests push expected masks,
// a monitor checks mask, err_sew and latency when the DUT presents mask_valid.
module tb_vec_compare_ctrl;
  import vec_cmp_pkg::*;

  localparam int VLEN = 4096;
  localparam int PW   = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_cmp_op;
  logic [1:0]      req_sew;
  logic [12:0]     req_vl;
  logic            req_vm;
  logic [VLEN-1:0] req_vs1, req_vs2, req_v0, req_old_vd;
  logic [VLEN-1:0] cmp_a, cmp_b, cmp_result, mask_out;
  logic [2:0]      cmp_op;
  logic [1:0]      cmp_sew;
  logic            mask_valid, mask_ready, busy, err_sew;

  vec_compare_ctrl #(.VLEN(VLEN), .PACK_W(PW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmp_op(req_cmp_op), .req_sew(req_sew), .req_vl(req_vl), .req_vm(req_vm),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_v0(req_v0), .req_old_vd(req_old_vd),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_sew(cmp_sew),
    .cmp_result(cmp_result),
    .mask_out(mask_out), .mask_valid(mask_valid), .mask_ready(mask_ready),
    .busy(busy), .err_sew(err_sew)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Compare datapath model: element result lands on the element's LSB.
  function automatic logic [VLEN-1:0] dp_model(logic [VLEN-1:0] a, logic [VLEN-1:0] b,
                                               logic [2:0] op, logic [1:0] sew);
    logic [VLEN-1:0] r;
    logic [63:0]     m, ua, ub, sbit;
    longint          sa, sb;
    logic            res;
    int              w;
    r = '0;
    if (sew == 2'b11) return r;
    w    = 8 << sew;
    m    = (64'd1 << w) - 64'd1;
    sbit = 64'd1 << (w - 1);
    for (int e = 0; e < VLEN / w; e++) begin
      ua = 64'(a >> (e * w)) & m;
      ub = 64'(b >> (e * w)) & m;
      sa = longint'(ua ^ sbit) - longint'(sbit);
      sb = longint'(ub ^ sbit) - longint'(sbit);
      case (cmp_op_e'(op))
        CMP_EQ:  res = (ua == ub);
        CMP_NE:  res = (ua != ub);
        CMP_LTU: res = (ua < ub);
        CMP_LEU: res = (ua <= ub);
        CMP_LT:  res = (sa < sb);
        CMP_LE:  res = (sa <= sb);
        CMP_GT:  res = (sa > sb);
        default: res = (ua > ub);
      endcase
      r[e * w] = res;
    end
    return r;
  endfunction

  assign cmp_result = dp_model(cmp_a, cmp_b, cmp_op, cmp_sew);

  typedef struct {
    logic [VLEN-1:0] mask;
    logic            err;
    int              due;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk_int(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_mask(string name, logic [VLEN-1:0] act, logic [VLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      for (int i = 0; i < VLEN; i++)
        if (act[i] !== exp[i]) begin
          $display("FAIL %s: bit %0d got %b, want %b (cycle %0d)", name, i, act[i], exp[i], cyc);
          break;
        end
    end
  endtask

  // Monitor: first sight of mask_valid checks value/err/latency; handshake pops.
  bit seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 1'b0;
      end else if (mask_valid) begin
        if (sb_q.size() == 0) begin
          if (!seen) chk_int("unexpected_mask_valid", 1, 0);
          seen = 1'b1;
        end else if (!seen) begin
          seen = 1'b1;
          chk_int("latency", cyc, sb_q[0].due);
          chk_mask("mask_first", mask_out, sb_q[0].mask);
          chk_int("err_sew", err_sew, sb_q[0].err);
        end
        if (mask_ready) begin
          if (sb_q.size() != 0) begin
            chk_mask("mask_handshake", mask_out, sb_q[0].mask);
            void'(sb_q.pop_front());
          end
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] sew, input logic [12:0] vl,
                       input logic vm, input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2,
                       input logic [VLEN-1:0] v0, input logic [VLEN-1:0] old,
                       input logic [VLEN-1:0] exp_mask, input logic exp_err,
                       input int npack, input bit push);
    exp_t x;
    @(negedge clk);
    chk_int("accept_ready", req_ready, 1);
    req_cmp_op = op; req_sew = sew; req_vl = vl; req_vm = vm;
    req_vs1 = vs1; req_vs2 = vs2; req_v0 = v0; req_old_vd = old;
    req_valid = 1'b1;
    if (push) begin
      x.mask = exp_mask; x.err = exp_err; x.due = cyc + 2 + npack;
      sb_q.push_back(x);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int i;
    for (i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
    chk_int(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  logic [VLEN-1:0] pat, pat2, z, vs1, vs2, v0, exp_m;
  bit ok, stable, quiet;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; mask_ready = 1'b1;
    req_cmp_op = '0; req_sew = '0; req_vl = '0; req_vm = 1'b0;
    req_vs1 = '0; req_vs2 = '0; req_v0 = '0; req_old_vd = '0;
    pat  = {128{32'hC3A5_5A3C}};
    pat2 = ~pat;
    z    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("rst_req_ready", req_ready, 1);
    chk_int("rst_busy", busy, 0);
    chk_int("rst_mask_valid", mask_valid, 0);
    chk_int("rst_err_sew", err_sew, 0);
    chk_int("rst_cmp_ctl", {cmp_op, cmp_sew}, 0);
    chk_mask("rst_mask_out", mask_out, z);
    chk_mask("rst_cmp_a", cmp_a, z);
    reset = 1'b0;

    // SEW8 EQ on equal operands, vl=512: 16 pack cycles
    vs1 = {128{32'h1234_5678}};
    exp_m = pat; exp_m[511:0] = '1;
    issue(3'b000, 2'b00, 13'd512, 1'b1, vs1, vs1, z, pat, exp_m, 1'b0, 16, 1'b1);
    drain("drain_eq512");

    // SEW32 signed LT against zero
    vs2 = '0;
    vs2[31:0] = 32'hFFFF_FFFF; vs2[63:32] = 32'd3; vs2[95:64] = 32'd0;
    vs2[127:96] = 32'd7; vs2[159:128] = 32'hFFFF_FFF8;
    exp_m = pat; exp_m[4:0] = 5'b10001;
    issue(3'b100, 2'b10, 13'd5, 1'b1, z, vs2, z, pat, exp_m, 1'b0, 1, 1'b1);
    drain("drain_lt5");

    // SEW16 NE masked by v0, two pack cycles
    vs2 = {256{16'h0001}};
    v0 = '0; v0[39:0] = 40'hAA_AAAA_AAAA;
    exp_m = '0; exp_m[39:0] = 40'hAA_AAAA_AAAA;
    issue(3'b001, 2'b01, 13'd40, 1'b0, z, vs2, v0, z, exp_m, 1'b0, 2, 1'b1);
    drain("drain_ne40");

    // vl=0: no pack, old_vd returned
    issue(3'b000, 2'b00, 13'd0, 1'b1, z, z, z, pat2, pat2, 1'b0, 0, 1'b1);
    drain("drain_vl0");

    // sew=11: error flagged, old_vd returned
    issue(3'b000, 2'b11, 13'd10, 1'b1, z, z, z, pat, pat, 1'b1, 0, 1'b1);
    drain("drain_sew11");

    // vl clamps to VLEN/32 = 128 elements
    vs1 = {128{32'd3}}; vs2 = {128{32'd5}};
    exp_m = pat; exp_m[127:0] = '1;
    issue(3'b111, 2'b10, 13'd200, 1'b1, vs1, vs2, z, pat, exp_m, 1'b0, 4, 1'b1);
    drain("drain_clamp");

    // SEW8 signed GT with v0 disabling element 1
    vs2 = '0; vs2[31:0] = 32'hFF01_7F80;
    v0 = '0; v0[3:0] = 4'b1101;
    exp_m = pat; exp_m[3:0] = 4'b0100;
    issue(3'b110, 2'b00, 13'd4, 1'b0, z, vs2, v0, pat, exp_m, 1'b0, 1, 1'b1);
    drain("drain_gt4");

    // Stall in DONE for 10 cycles with mask_ready low
    @(posedge clk); #1 mask_ready = 1'b0;
    vs1 = {128{32'h0F0F_0F0F}};
    exp_m = pat2; exp_m[32:0] = '1;
    issue(3'b011, 2'b00, 13'd33, 1'b1, vs1, vs1, z, pat2, exp_m, 1'b0, 2, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mask_valid) begin ok = 1'b1; break; end
    end
    chk_int("stall_reach_done", ok, 1);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!mask_valid || req_ready || (mask_out !== exp_m)) stable = 1'b0;
    end
    chk_int("stall_hold", stable, 1);
    @(posedge clk); #1 mask_ready = 1'b1;
    @(negedge clk);
    chk_int("done_exit_no_ready", req_ready, 0);
    @(negedge clk);
    chk_int("idle_ready_after", req_ready, 1);
    drain("drain_stall");

    // Reset in the middle of PACK discards the operation
    vs1 = {128{32'h5555_AAAA}};
    issue(3'b000, 2'b00, 13'd512, 1'b1, vs1, vs1, z, pat, pat, 1'b0, 16, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_int("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_int("midrst_req_ready", req_ready, 1);
    chk_int("midrst_busy", busy, 0);
    chk_int("midrst_mask_valid", mask_valid, 0);
    chk_mask("midrst_mask_out", mask_out, z);
    @(negedge clk); reset = 1'b0;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (mask_valid || busy) quiet = 1'b0;
    end
    chk_int("midrst_no_valid", quiet, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
